// File: rtl/axi_burst_reader.sv
// AXI4 read initiator: splits a (start address, beat count) command into INCR bursts, capped at MAX_BURST and never crossing 4 KB.
// Data passes straight from R to the out port with no buffering; out_ready drives rready directly, and only one burst is outstanding at a time.
module axi_burst_reader #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int AXI_ID     = 0,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [15:0]           cmd_beats,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  done,
    output logic                  err,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SIZE  = $clog2(BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [15:0]             remaining_q, remaining_d;
    logic [7:0]              beat_cnt_q, beat_cnt_d;
    logic [7:0]              arlen_q, arlen_d;
    logic                    arvalid_q, arvalid_d;
    logic                    err_q, err_d;

    logic                    r_hs;
    logic                    burst_end;
    logic [ADDR_WIDTH-1:0]   burst_bytes;

    // Beats allowed from this address: remaining work, burst cap, and room left in the 4 KB page.
    function automatic logic [8:0] burst_beats(input logic [11:0] page_off, input logic [15:0] rem);
        logic [12:0] page_left;
        logic [15:0] beats;
        page_left = 13'h1000 - {1'b0, page_off};
        beats     = 16'(page_left >> SIZE);
        if (beats > 16'(MAX_BURST)) beats = 16'(MAX_BURST);
        if (rem < beats) beats = rem;
        return 9'(beats);
    endfunction

    assign m_axi_arid    = ID_WIDTH'(AXI_ID);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = 3'(SIZE);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;

    assign cmd_ready    = (state_q == S_IDLE);
    assign done         = (state_q == S_DONE);
    assign err          = err_q;
    assign out_data     = m_axi_rdata;
    assign out_valid    = (state_q == S_R) && m_axi_rvalid;
    assign m_axi_rready = (state_q == S_R) && out_ready;
    assign out_last     = out_valid && (remaining_q == 16'd1);

    assign r_hs        = (state_q == S_R) && m_axi_rvalid && out_ready;
    assign burst_end   = (beat_cnt_q == arlen_q);
    assign burst_bytes = ADDR_WIDTH'({1'b0, arlen_q} + 9'd1) << SIZE;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        beat_cnt_d  = beat_cnt_q;
        arlen_d     = arlen_q;
        arvalid_d   = arvalid_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d      = cmd_addr & ALIGN_MASK;
                    remaining_d = cmd_beats;
                    err_d       = 1'b0;
                    if (cmd_beats == 16'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_AR;
                        arvalid_d = 1'b1;
                        arlen_d   = 8'(burst_beats(addr_d[11:0], remaining_d) - 9'd1);
                    end
                end
            end
            S_AR: begin
                if (m_axi_arready) begin
                    arvalid_d  = 1'b0;
                    beat_cnt_d = 8'd0;
                    state_d    = S_R;
                end
            end
            S_R: begin
                if (r_hs) begin
                    remaining_d = remaining_q - 16'd1;
                    beat_cnt_d  = beat_cnt_q + 8'd1;
                    if (m_axi_rresp[1] || (m_axi_rid != ID_WIDTH'(AXI_ID)) || (m_axi_rlast != burst_end))
                        err_d = 1'b1;
                    // Burst length is ours; rlast is only checked, never trusted.
                    if (burst_end) begin
                        if (remaining_q == 16'd1) begin
                            state_d = S_DONE;
                        end else begin
                            addr_d    = addr_q + burst_bytes;
                            state_d   = S_AR;
                            arvalid_d = 1'b1;
                            arlen_d   = 8'(burst_beats(addr_d[11:0], remaining_d) - 9'd1);
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            beat_cnt_q  <= '0;
            arlen_q     <= '0;
            arvalid_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            beat_cnt_q  <= beat_cnt_d;
            arlen_q     <= arlen_d;
            arvalid_q   <= arvalid_d;
            err_q       <= err_d;
        end
    end

endmodule
